regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor of the lab-1 MIPS register file, for the pipelined datapath.
- Two combinational read ports and two synchronous write ports, with optional hardwired-zero register 0 and optional write-to-read bypass.
- After reset, a sequential clear walk zeroes every register; no preload file is used.
- A per-register busy scoreboard tracks outstanding writes so hazard logic can stall.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 32, number of registers, at most 2**ADDR_W.
- ZERO_REG, 1. When 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1. When 1, a same-cycle write is forwarded to a matching read port.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst_n, in, 1, reset, synchronous, active-low.
- i_raddr1, in, ADDR_W, read address for port 1.
- i_raddr2, in, ADDR_W, read address for port 2.
- o_rdata1, out, DATA_W, read data for port 1, combinational.
- o_rdata2, out, DATA_W, read data for port 2, combinational.
- i_we1, in, 1, write enable for port 1.
- i_waddr1, in, ADDR_W, write address for port 1.
- i_wdata1, in, DATA_W, write data for port 1.
- i_we2, in, 1, write enable for port 2; port 2 has priority over port 1.
- i_waddr2, in, ADDR_W, write address for port 2.
- i_wdata2, in, DATA_W, write data for port 2.
- i_iss_valid, in, 1, an instruction with destination i_iss_addr was issued.
- i_iss_addr, in, ADDR_W, destination register of the issued instruction.
- o_busy1, out, 1, register at i_raddr1 has a pending write.
- o_busy2, out, 1, register at i_raddr2 has a pending write.
- o_ready, out, 1, clear walk is done and the file accepts traffic.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is synchronous and active-low.
- State machine, two states, INIT and RUN:
  - Any cycle with i_rst_n=0: next state INIT, clear counter = 0, all busy bits = 0, o_ready = 0 on the next cycle.
  - INIT (i_rst_n=1): write 0 to register[counter], then counter+1. When counter == DEPTH-1 that entry is cleared and the next state is RUN.
  - INIT therefore lasts exactly DEPTH cycles after reset release. o_ready = 1 exactly in RUN.
  - Reset asserted mid-walk restarts the walk at 0.
- Outputs during INIT and reset:
  - o_rdata1, o_rdata2, o_busy1 and o_busy2 are all 0.
  - i_we1, i_we2 and i_iss_valid are ignored; nothing is stored or set.
- Writes in RUN:
  - On the rising edge, register[waddrN] <= wdataN when weN=1.
  - Both ports writing the same address: port 2 data is stored.
  - Any address >= DEPTH is ignored.
  - ZERO_REG=1: writes to address 0 are ignored.
- Reads:
  - o_rdataN = register[raddrN], combinational.
  - raddrN >= DEPTH returns 0. ZERO_REG=1 and raddrN == 0 returns 0.
  - BYPASS=1: if a valid write in this cycle targets raddrN, o_rdataN shows that write data, with port 2 winning over port 1. Zero-register and out-of-range rules still apply.
  - BYPASS=0: reads return the pre-edge contents.
- Scoreboard (RUN only):
  - i_iss_valid sets busy[i_iss_addr] at the edge.
  - A write on either port clears busy[waddr] at the edge.
  - Issue and write to the same address in one cycle: the busy bit stays set, because the new producer wins.
  - ZERO_REG=1: address 0 is never set busy.
  - Address >= DEPTH: no effect on the scoreboard.
  - o_busyN = busy[raddrN] AND NOT (BYPASS=1 AND a write in this cycle hits raddrN).
- Latency: write-to-read latency is 0 cycles with bypass and 1 cycle without.

Test Plan:
- Release reset with DEPTH=32 -> o_ready = 0 for exactly 32 cycles, then 1. Every register then reads 0x00000000.
- In RUN, write 0xDEADBEEF to r5 on port 1 and 0x12345678 to r5 on port 2 in the same cycle -> r5 reads 0x12345678 next cycle. With BYPASS=1, o_rdata1 at raddr1=5 shows 0x12345678 in the write cycle itself.
- ZERO_REG=1, write 0xFFFFFFFF to r0 and issue to r0 -> o_rdata1 = 0 and o_busy1 = 0 at raddr1=0.
- Issue r7, then 2 idle cycles, then write r7 = 0x00000042 -> o_busy1 = 1 during the idle cycles. In the write cycle o_busy1 = 0 with the bypassed value 0x42 (BYPASS=1). After the edge o_busy1 = 0.
- Issue r9 and write r9 in the same cycle -> busy[r9] stays 1 afterwards.
- Assert i_rst_n=0 at walk cycle 10, after writing r3 = 0xAA in RUN before that -> walk restarts, o_ready = 0 for 32 further cycles, r3 reads 0 and all busy bits are 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: two read ports, two write ports and the issue
// strobe that feeds the busy scoreboard. The clock and reset are not part of it.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] i_raddr1;
  logic [ADDR_W-1:0] i_raddr2;
  logic [DATA_W-1:0] o_rdata1;
  logic [DATA_W-1:0] o_rdata2;
  logic              i_we1;
  logic [ADDR_W-1:0] i_waddr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              i_we2;
  logic [ADDR_W-1:0] i_waddr2;
  logic [DATA_W-1:0] i_wdata2;
  logic              i_iss_valid;
  logic [ADDR_W-1:0] i_iss_addr;
  logic              o_busy1;
  logic              o_busy2;
  logic              o_ready;

  modport master (
    output i_raddr1, i_raddr2, i_we1, i_waddr1, i_wdata1,
           i_we2, i_waddr2, i_wdata2, i_iss_valid, i_iss_addr,
    input  o_rdata1, o_rdata2, o_busy1, o_busy2, o_ready
  );

  modport slave (
    input  i_raddr1, i_raddr2, i_we1, i_waddr1, i_wdata1,
           i_we2, i_waddr2, i_wdata2, i_iss_valid, i_iss_addr,
    output o_rdata1, o_rdata2, o_busy1, o_busy2, o_ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/two-write register file for the pipelined datapath, with a
// post-reset clear walk, optional hardwired r0, write bypass and busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  regfile_mp_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              busy;
  } rd_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic run;
  logic wv1;
  logic wv2;
  logic iss_ok;
  rd_t  rd1;
  rd_t  rd2;

  // An address is usable when it is in range and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run    = (state_q == ST_RUN) && i_rst_n;
  assign wv1    = run && bus.i_we1       && addr_ok(bus.i_waddr1);
  assign wv2    = run && bus.i_we2       && addr_ok(bus.i_waddr2);
  assign iss_ok = run && bus.i_iss_valid && addr_ok(bus.i_iss_addr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_C) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; the clear walk zeroes it, so it maps to resetless storage.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state_q == ST_INIT) begin
        regs_q[cnt_q] <= '0;
      end else begin
        if (wv1) regs_q[bus.i_waddr1] <= bus.i_wdata1;
        if (wv2) regs_q[bus.i_waddr2] <= bus.i_wdata2;
      end
    end
  end

  // Issue is applied after the write clears so a new producer keeps the bit set.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    busy_d = busy_q;
    if (wv1)    busy_d[bus.i_waddr1]   = 1'b0;
    if (wv2)    busy_d[bus.i_waddr2]   = 1'b0;
    if (iss_ok) busy_d[bus.i_iss_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  function automatic rd_t read_port(input logic [ADDR_W-1:0] ra);
    rd_t r;
    r.data = '0;
    r.busy = 1'b0;
    if (run && addr_ok(ra)) begin
      r.data = regs_q[ra];
      r.busy = busy_q[ra];
      if (BYPASS != 0) begin
        if (wv1 && (bus.i_waddr1 == ra)) begin
          r.data = bus.i_wdata1;
          r.busy = 1'b0;
        end
        if (wv2 && (bus.i_waddr2 == ra)) begin
          r.data = bus.i_wdata2;
          r.busy = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rd1 = read_port(bus.i_raddr1);
    rd2 = read_port(bus.i_raddr2);
  end

  assign bus.o_rdata1 = rd1.data;
  assign bus.o_rdata2 = rd2.data;
  assign bus.o_busy1  = rd1.busy;
  assign bus.o_busy2  = rd2.busy;
  assign bus.o_ready  = ready_q;

endmodule
